// File: rtl/pll_drp_pkg.sv
// pll_drp_pkg: shared types and constants for the PLL CLKOUT0 DRP sequencer.
//   state_t      - sequencer states
//   REG*_ADDR    - DRP addresses of the two CLKOUT0 configuration registers
//   REG*_KEEP    - bits of each register that must survive the rewrite
//   div_enc_t    - HIGH/LOW/EDGE/NO_COUNT fields for one divide value
//   encode_div   - divide value -> field encoding
//   merge_reg    - read-back word + fields -> word to write
package pll_drp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RELEASE,
        S_LOCK_WAIT
    } state_t;

    localparam logic [6:0]  REG1_ADDR = 7'h08;
    localparam logic [6:0]  REG2_ADDR = 7'h09;
    localparam logic [15:0] REG1_KEEP = 16'hF000;
    localparam logic [15:0] REG2_KEEP = 16'hFF3F;

    localparam int HIGH_LSB  = 6;
    localparam int LOW_LSB   = 0;
    localparam int EDGE_BIT  = 7;
    localparam int NOCNT_BIT = 6;

    typedef struct packed {
        logic [5:0] high;
        logic [5:0] low;
        logic       edge_bit;
        logic       no_count;
    } div_enc_t;

    // Only called with 1..128. Six-bit fields wrap naturally, so a count of
    // 64 lands as 0; LOW is formed modulo 64 from the low bits of D.
    function automatic div_enc_t encode_div(input logic [7:0] d);
        div_enc_t e;
        if (d == 8'd1) begin
            e.high     = 6'd1;
            e.low      = 6'd1;
            e.edge_bit = 1'b0;
            e.no_count = 1'b1;
        end else begin
            e.high     = d[6:1];
            e.low      = d[5:0] - d[6:1];
            e.edge_bit = d[0];
            e.no_count = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [15:0] merge_reg(input logic       second,
                                              input logic [15:0] rd,
                                              input div_enc_t    e);
        logic [15:0] w;
        if (!second)
            w = (rd & REG1_KEEP) | (16'(e.high) << HIGH_LSB) | (16'(e.low) << LOW_LSB);
        else
            w = (rd & REG2_KEEP) | (16'(e.edge_bit) << EDGE_BIT) | (16'(e.no_count) << NOCNT_BIT);
        return w;
    endfunction

endpackage

// File: rtl/pll_drp_sync.sv
// pll_drp_sync: two-flop synchronizer for the PLL LOCKED flag.
//   clk_i   - destination clock
//   rst_i   - asynchronous reset, active high (output reads unlocked)
//   async_i - asynchronous input
//   sync_o  - synchronized output
module pll_drp_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta   <= 1'b0;
            sync_o <= 1'b0;
        end else begin
            meta   <= async_i;
            sync_o <= meta;
        end
    end

endmodule

// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: reprograms the PLL CLKOUT0 divider over DRP.
// Holds the PLL in reset, read-modify-writes REG1 then REG2, releases reset
// and waits for lock. done_o / err_o are single-cycle pulses.
//   clk_i, rst_i          - DRP clock, async active-high reset
//   req_i, req_div_i      - request and divide value (1..128 legal)
//   busy_o, done_o, err_o - status
//   pll_rst_o             - PLL RST
//   daddr_o, den_o, dwe_o, di_o, do_i, drdy_i - DRP port
//   locked_i              - PLL LOCKED (asynchronous)
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [7:0]  req_div_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        pll_rst_o,
    output logic [6:0]  daddr_o,
    output logic        den_o,
    output logic        dwe_o,
    output logic [15:0] di_o,
    input  logic [15:0] do_i,
    input  logic        drdy_i,
    input  logic        locked_i
);

    localparam int CNT_W = $clog2(RST_HOLD + DRDY_TIMEOUT + LOCK_TIMEOUT + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    div_enc_t         enc;
    logic             second;   // REG2 pass in progress
    logic             locked_sync;

    pll_drp_sync u_lock_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (locked_i),
        .sync_o  (locked_sync)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            cnt       <= '0;
            enc       <= '0;
            second    <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            pll_rst_o <= 1'b0;
            daddr_o   <= '0;
            den_o     <= 1'b0;
            dwe_o     <= 1'b0;
            di_o      <= '0;
        end else begin
            den_o  <= 1'b0;
            dwe_o  <= 1'b0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_i) begin
                        if (req_div_i == 8'd0 || req_div_i > 8'd128) begin
                            err_o <= 1'b1;
                        end else begin
                            enc       <= encode_div(req_div_i);
                            second    <= 1'b0;
                            busy_o    <= 1'b1;
                            pll_rst_o <= 1'b1;
                            cnt       <= '0;
                            state     <= S_RST_HOLD;
                        end
                    end
                end
                S_RST_HOLD: begin
                    if (cnt == CNT_W'(RST_HOLD - 1)) begin
                        den_o   <= 1'b1;
                        daddr_o <= REG1_ADDR;
                        state   <= S_RD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RD: begin
                    cnt   <= '0;
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Write word is formed straight from the returned data so
                    // it is valid in the same cycle den_o rises for the write.
                    if (drdy_i) begin
                        di_o  <= merge_reg(second, do_i, enc);
                        den_o <= 1'b1;
                        dwe_o <= 1'b1;
                        state <= S_WR;
                    end else if (cnt == CNT_W'(DRDY_TIMEOUT - 1)) begin
                        pll_rst_o <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WR: begin
                    cnt   <= '0;
                    state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (drdy_i) begin
                        if (!second) begin
                            second  <= 1'b1;
                            den_o   <= 1'b1;
                            daddr_o <= REG2_ADDR;
                            state   <= S_RD;
                        end else begin
                            pll_rst_o <= 1'b0;
                            state     <= S_RELEASE;
                        end
                    end else if (cnt == CNT_W'(DRDY_TIMEOUT - 1)) begin
                        pll_rst_o <= 1'b0;
                        busy_o    <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    cnt   <= '0;
                    state <= S_LOCK_WAIT;
                end
                S_LOCK_WAIT: begin
                    // The first LOCK_WAIT cycle is blanked so the synchronizer
                    // has flushed samples taken before RST was released.
                    if (locked_sync && cnt != '0) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
module tb_pll_drp_ctrl;

    localparam int RH = 16;
    localparam int DT = 64;
    localparam int LT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [7:0]  req_div_i;
    logic        busy_o, done_o, err_o, pll_rst_o;
    logic [6:0]  daddr_o;
    logic        den_o, dwe_o;
    logic [15:0] di_o;
    logic [15:0] do_i = 16'h0;
    logic        drdy_i = 1'b0;
    logic        locked_i;

    always #5 clk = ~clk;

    pll_drp_ctrl #(.RST_HOLD(RH), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req_i), .req_div_i(req_div_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .pll_rst_o(pll_rst_o),
        .daddr_o(daddr_o), .den_o(den_o), .dwe_o(dwe_o), .di_o(di_o),
        .do_i(do_i), .drdy_i(drdy_i), .locked_i(locked_i)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // DRP slave model: answers each access after 'lat' cycles, returns the
    // preloaded register contents on reads, logs writes.
    logic [15:0] ini1 = 16'h0, ini2 = 16'h0;
    int          lat = 1;
    bit          hold_wr2 = 1'b0;
    int          pend = 0;
    logic [15:0] rdata = 16'h0;
    logic [6:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    int          bad_addr = 0, den_b2b = 0, both_hi = 0;
    logic        den_prev = 1'b0;

    always @(negedge clk) begin
        drdy_i = 1'b0;
        if (rst) pend = 0;
        else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drdy_i = 1'b1;
                do_i   = rdata;
            end
        end
        if (den_o) begin
            if (den_prev) den_b2b++;
            if (daddr_o != 7'h08 && daddr_o != 7'h09) bad_addr++;
            if (!dwe_o) rdata = (daddr_o == 7'h08) ? ini1 : ini2;
            else begin
                wq_addr.push_back(daddr_o);
                wq_data.push_back(di_o);
            end
            if (!(hold_wr2 && dwe_o && daddr_o == 7'h09)) pend = lat;
        end
        den_prev = den_o;
        if (done_o && err_o) both_hi++;
    end

    // Reference: register contents after reprogramming, from the encoding rules.
    function automatic logic [15:0] exp_reg(input int d, input bit second, input logic [15:0] init);
        int hi, lo, ed, nc;
        if (d == 1) begin hi = 1; lo = 1; ed = 0; nc = 1; end
        else begin hi = d / 2; lo = d - hi; ed = d % 2; nc = 0; end
        hi = hi % 64;
        lo = lo % 64;
        if (!second) return (init & 16'hF000) | 16'(hi * 64 + lo);
        return (init & 16'hFF3F) | 16'(ed * 128 + nc * 64);
    endfunction

    int  r_done, r_err, r_den1, r_rst, r_den;
    bit  r_busy1, r_rst_end, r_busy_end;

    task automatic run_req(input logic [7:0] d, input bit pester, input int bound);
        int cyc;
        r_done = -1; r_err = -1; r_den1 = -1; r_rst = 0; r_den = 0;
        r_busy1 = 1'b0; r_rst_end = 1'b1; r_busy_end = 1'b1;
        @(negedge clk);
        req_i = 1'b1;
        req_div_i = d;
        cyc = 0;
        while (cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (pll_rst_o) r_rst++;
            if (den_o) begin
                r_den++;
                if (r_den1 < 0) r_den1 = cyc;
            end
            if (cyc == 1) r_busy1 = busy_o;
            if (done_o || err_o) begin
                if (done_o) r_done = cyc;
                if (err_o) r_err = cyc;
                r_rst_end  = pll_rst_o;
                r_busy_end = busy_o;
                break;
            end
            req_i = pester ? ~req_i : 1'b0;
        end
        req_i = 1'b0;
        if (r_done < 0 && r_err < 0) chk("completion_timeout", cyc, -1);
    endtask

    task automatic check_legal(input string tag, input logic [7:0] d,
                               input logic [15:0] i1, input logic [15:0] i2,
                               input logic [15:0] e1, input logic [15:0] e2);
        int base;
        ini1 = i1;
        ini2 = i2;
        base = wq_data.size();
        run_req(d, 1'b0, 600);
        chk({tag, "_busy1"}, r_busy1, 1);
        chk({tag, "_done_cyc"}, r_done, RH + 12 + 4 * (lat - 1));
        chk({tag, "_err"}, r_err, -1);
        chk({tag, "_first_den"}, r_den1, RH + 1);
        chk({tag, "_rst_cycles"}, r_rst, RH + 8 + 4 * (lat - 1));
        chk({tag, "_den_cnt"}, r_den, 4);
        chk({tag, "_busy_end"}, r_busy_end, 0);
        chk({tag, "_nwrites"}, wq_data.size() - base, 2);
        if (wq_data.size() >= base + 2) begin
            chk({tag, "_wr1_addr"}, wq_addr[base], 8);
            chk({tag, "_wr1_data"}, wq_data[base], e1);
            chk({tag, "_wr2_addr"}, wq_addr[base+1], 9);
            chk({tag, "_wr2_data"}, wq_data[base+1], e2);
        end
    endtask

    task automatic check_illegal(input string tag, input logic [7:0] d);
        run_req(d, 1'b0, 50);
        chk({tag, "_err_cyc"}, r_err, 1);
        chk({tag, "_done"}, r_done, -1);
        chk({tag, "_den_cnt"}, r_den, 0);
        chk({tag, "_rst_cycles"}, r_rst, 0);
        chk({tag, "_busy1"}, r_busy1, 0);
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [15:0] i1, i2;
        bit          bad;
        logic [15:0] e1, e2;
    } vec_t;

    vec_t tv[8];

    initial begin
        int n_busy, n_den;
        logic [7:0]  rd;
        logic [15:0] ri1, ri2;

        tv[0] = '{8'd60,  16'hA5C3, 16'hA5C3, 1'b0, 16'hA79E, 16'hA503};
        tv[1] = '{8'd1,   16'h0000, 16'hFFFF, 1'b0, 16'h0041, 16'hFF7F};
        tv[2] = '{8'd7,   16'h0000, 16'h0000, 1'b0, 16'h00C4, 16'h0080};
        tv[3] = '{8'd128, 16'hFFFF, 16'hFFFF, 1'b0, 16'hF000, 16'hFF3F};
        tv[4] = '{8'd0,   16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        tv[5] = '{8'd200, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        tv[6] = '{8'd2,   16'h1234, 16'h0000, 1'b0, 16'h1041, 16'h0000};
        tv[7] = '{8'd127, 16'h0FFF, 16'h00C0, 1'b0, 16'h0FC0, 16'h0080};

        rst = 1'b1; req_i = 1'b0; req_div_i = 8'd0; locked_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, err_o, pll_rst_o, den_o, dwe_o, daddr_o, di_o}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            if (tv[i].bad) check_illegal($sformatf("tv%0d", i), tv[i].d);
            else check_legal($sformatf("tv%0d", i), tv[i].d, tv[i].i1, tv[i].i2, tv[i].e1, tv[i].e2);
        end

        // Randomized requests and DRP latencies against the reference
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) rd = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(129, 255));
            else rd = 8'($urandom_range(1, 128));
            ri1 = 16'($urandom);
            ri2 = 16'($urandom);
            lat = $urandom_range(1, 4);
            if (rd == 8'd0 || rd > 8'd128) check_illegal($sformatf("rnd%0d", i), rd);
            else check_legal($sformatf("rnd%0d", i), rd, ri1, ri2,
                             exp_reg(rd, 1'b0, ri1), exp_reg(rd, 1'b1, ri2));
        end
        lat = 1;

        // REG2 write never acknowledged
        hold_wr2 = 1'b1;
        ini1 = 16'h0; ini2 = 16'h0;
        run_req(8'd60, 1'b0, 300);
        chk("drdy_to_err_cyc", r_err, RH + 8 + DT);
        chk("drdy_to_done", r_done, -1);
        chk("drdy_to_rst_end", r_rst_end, 0);
        chk("drdy_to_busy_end", r_busy_end, 0);
        hold_wr2 = 1'b0;
        check_legal("after_drdy_to", 8'd10, 16'hFFFF, 16'h0000, 16'hF145, 16'h0000);

        // Lock never arrives
        locked_i = 1'b0;
        repeat (3) @(negedge clk);
        run_req(8'd60, 1'b0, 1000);
        chk("lock_to_err_cyc", r_err, RH + 10 + LT);
        chk("lock_to_done", r_done, -1);
        chk("lock_to_rst_end", r_rst_end, 0);
        locked_i = 1'b1;
        repeat (3) @(negedge clk);

        // Reset while waiting for a read response
        lat = 5;
        @(negedge clk);
        req_i = 1'b1; req_div_i = 8'd60;
        @(negedge clk);
        req_i = 1'b0;
        n_den = 0;
        for (int c = 0; c < 40 && !den_o; c++) @(negedge clk);
        chk("mid_rst_saw_den", den_o, 1);
        @(negedge clk);
        chk("mid_rst_pll_rst_before", pll_rst_o, 1);
        #2 rst = 1'b1;
        #1 chk("mid_rst_outputs", {busy_o, done_o, err_o, pll_rst_o, den_o, dwe_o, daddr_o, di_o}, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        lat = 1;
        repeat (4) @(negedge clk);
        chk("mid_rst_idle_busy", busy_o, 0);
        check_legal("after_mid_rst", 8'd60, 16'hA5C3, 16'hA5C3, 16'hA79E, 16'hA503);

        // Repeated requests while busy
        run_req(8'd60, 1'b1, 600);
        chk("pester_done_cyc", r_done, RH + 12);
        chk("pester_den_cnt", r_den, 4);
        n_busy = 0;
        n_den = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy_o) n_busy++;
            if (den_o || done_o) n_den++;
        end
        chk("pester_no_second_busy", n_busy, 0);
        chk("pester_no_second_run", n_den, 0);

        chk("den_back_to_back", den_b2b, 0);
        chk("bad_drp_addr", bad_addr, 0);
        chk("done_err_together", both_hi, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
